swd_frame_engine: RTL and testbench

Parametrised SWD transaction engine, the successor to the pass-through SPI-to-SWD front end. Instead of relying on the host to bit-bang headers, it accepts a single request word per transaction. It then generates SWCLK, serialises the 8-bit header and handles the turnaround cycles. It samples ACK, moves DATA_W data bits with parity, and appends idle cycles. It sits between the probe's command layer and the external SWDIO tri-state buffer.

---
 rtl/swd_pkg.sv | 33 +++
 rtl/swd_clk_gen.sv | 51 +++++
 rtl/swd_frame_engine.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_swd_frame_engine.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swd_pkg.sv
// SWD frame engine shared types: FSM states, ACK codes, header builder.
// Imported by swd_clk_gen and swd_frame_engine.
package swd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    TRN1,
    ACK,
    RDATA,
    TRN2,
    WDATA,
    POST
  } state_t;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  // bit 0 goes on the wire first:
  // start, APnDP, RnW, A2, A3, parity, stop, park
  function automatic logic [7:0] swd_header(
    input logic       apndp,
    input logic       rnw,
    input logic [1:0] addr
  );
    logic par;
    par = apndp ^ rnw ^ addr[0] ^ addr[1];
    return {1'b1, 1'b0, par, addr[1], addr[0],
            rnw, apndp, 1'b1};
  endfunction

endpackage

// File: rtl/swd_clk_gen.sv
// SWCLK divider: low phase then high phase, CLK_DIV sck each.
// Ports: sck, rst_n, en in; swclk, fall, rise, start strobes out.
module swd_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic sck,
  input  logic rst_n,
  input  logic en,
  output logic swclk,
  output logic fall,
  output logic rise,
  output logic start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic          run;
  logic [DW-1:0] cnt;

  // start is the first low-phase edge after enable
  always_comb begin
    start = en && !run;
    fall  = start || (en && swclk && cnt == LAST);
    rise  = en && run && !swclk && cnt == LAST;
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      cnt   <= '0;
      swclk <= 1'b0;
    end else if (!en) begin
      run   <= 1'b0;
      cnt   <= '0;
      swclk <= 1'b0;
    end else begin
      run <= 1'b1;
      if (fall) begin
        cnt   <= '0;
        swclk <= 1'b0;
      end else if (rise) begin
        cnt   <= '0;
        swclk <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/swd_frame_engine.sv
// SWD transaction engine: request word in, full SWD frame out.
// Ports: req_* in, rsp_* out, swclk/swdio_* pins; SWD_WAIT_RETRY_EN.
module swd_frame_engine #(
  parameter int CLK_DIV      = 2,
  parameter int TRN_CYCLES   = 1,
  parameter int DATA_W       = 32,
  parameter int IDLE_CYCLES  = 8,
  parameter int WAIT_RETRIES = 8
) (
  input  logic              sck,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_apndp,
  input  logic              req_rnw,
  input  logic [1:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [2:0]        rsp_ack,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr,
  output logic [3:0]        rsp_retries,
  output logic              busy,
  output logic              swclk,
  output logic              swdio_o,
  output logic              swdio_oe,
  input  logic              swdio_i
);

  import swd_pkg::*;

`ifdef SWD_WAIT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int CW = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] DW_C   = CW'(DATA_W);
  localparam logic [CW-1:0] DW_C1  = CW'(DATA_W - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TRN_CYCLES - 1);
  localparam logic [7:0]    I_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0]    R_MAX  = 4'(WAIT_RETRIES);

  state_t state, state_n;

  logic [CW-1:0]     cnt, cnt_n;
  logic [7:0]        icnt, icnt_n;
  logic              o_n, oe_n;
  logic              ap_q, ap_n;
  logic              rnw_q, rnw_n;
  logic [1:0]        addr_q, addr_n;
  logic [DATA_W-1:0] wd_q, wd_n;
  logic [DATA_W-1:0] wsh, wsh_n;
  logic [2:0]        ack_sh, ack_n;
  logic [DATA_W-1:0] rsh, rsh_n;
  logic              rpar, rpar_n;
  logic [3:0]        retries, retries_n;
  logic              ready_n;
  logic              rv_n;
  logic [2:0]        rack_n;
  logic [DATA_W-1:0] rdata_n;
  logic              perr_n;
  logic [3:0]        rret_n;

  logic       fall, rise, start;
  logic [7:0] hdr;
  logic       wpar;
  logic       ack_ok;
  logic       rd_ok;
  logic       to_post, to_end;

  assign busy = (state != IDLE);

  swd_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk (
    .sck  (sck),
    .rst_n(rst_n),
    .en   (busy),
    .swclk(swclk),
    .fall (fall),
    .rise (rise),
    .start(start)
  );

  always_comb begin
    hdr    = swd_header(ap_q, rnw_q, addr_q);
    wpar   = ^wd_q;
    ack_ok = (ack_sh == ACK_OK);
    rd_ok  = ack_ok && rnw_q;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    icnt_n    = icnt;
    o_n       = swdio_o;
    oe_n      = swdio_oe;
    ap_n      = ap_q;
    rnw_n     = rnw_q;
    addr_n    = addr_q;
    wd_n      = wd_q;
    wsh_n     = wsh;
    ack_n     = ack_sh;
    rsh_n     = rsh;
    rpar_n    = rpar;
    retries_n = retries;
    ready_n   = req_ready;
    rv_n      = 1'b0;
    rack_n    = rsp_ack;
    rdata_n   = rsp_rdata;
    perr_n    = rsp_perr;
    rret_n    = rsp_retries;
    to_post   = 1'b0;
    to_end    = 1'b0;

    // ready returns the cycle after the response pulse
    if (rsp_valid) ready_n = 1'b1;

    if (state == IDLE && req_valid && req_ready) begin
      state_n   = HDR;
      cnt_n     = '0;
      ap_n      = req_apndp;
      rnw_n     = req_rnw;
      addr_n    = req_addr;
      wd_n      = req_wdata;
      ack_n     = '0;
      retries_n = '0;
      ready_n   = 1'b0;
    end

    if (rise) begin
      if (state == ACK) begin
        ack_n[cnt[1:0]] = swdio_i;
      end else if (state == RDATA) begin
        if (cnt == DW_C) rpar_n = swdio_i;
        else rsh_n = {swdio_i, rsh[DATA_W-1:1]};
      end
    end

    if (fall) begin
      if (start) begin
        oe_n = 1'b1;
        o_n  = hdr[0];
      end else begin
        unique case (state)
          IDLE: ;
          HDR: begin
            if (cnt == CW'(7)) begin
              state_n = TRN1;
              cnt_n   = '0;
              oe_n    = 1'b0;
              o_n     = 1'b0;
            end else begin
              cnt_n = cnt + 1'b1;
              o_n   = hdr[cnt_n[2:0]];
            end
          end
          TRN1: begin
            if (cnt == T_LAST) begin
              state_n = ACK;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          ACK: begin
            if (cnt == CW'(2)) begin
              cnt_n   = '0;
              state_n = rd_ok ? RDATA : TRN2;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          RDATA: begin
            if (cnt == DW_C) begin
              state_n = TRN2;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          TRN2: begin
            if (cnt == T_LAST) begin
              cnt_n = '0;
              if (ack_ok && !rnw_q) begin
                state_n = WDATA;
                oe_n    = 1'b1;
                o_n     = wd_q[0];
                wsh_n   = wd_q >> 1;
              end else begin
                to_post = 1'b1;
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          WDATA: begin
            if (cnt == DW_C) begin
              to_post = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
              if (cnt == DW_C1) begin
                o_n = wpar;
              end else begin
                o_n   = wsh[0];
                wsh_n = wsh >> 1;
              end
            end
          end
          POST: begin
            if (icnt == I_LAST) to_end = 1'b1;
            else icnt_n = icnt + 8'd1;
          end
        endcase
      end
    end

    if (to_post) begin
      if (IDLE_CYCLES == 0) begin
        to_end = 1'b1;
      end else begin
        state_n = POST;
        icnt_n  = '0;
        oe_n    = 1'b1;
        o_n     = 1'b0;
      end
    end

    if (to_end) begin
      if (RETRY_EN && ack_sh == ACK_WAIT
          && retries < R_MAX) begin
        // seamless reissue of the same header
        state_n   = HDR;
        cnt_n     = '0;
        oe_n      = 1'b1;
        o_n       = hdr[0];
        ack_n     = '0;
        retries_n = retries + 4'd1;
      end else begin
        state_n = IDLE;
        oe_n    = 1'b0;
        o_n     = 1'b0;
        rv_n    = 1'b1;
        rack_n  = ack_sh;
        rdata_n = rd_ok ? rsh : '0;
        perr_n  = rd_ok && ((^rsh) != rpar);
        rret_n  = retries;
      end
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      icnt        <= '0;
      swdio_o     <= 1'b0;
      swdio_oe    <= 1'b0;
      ap_q        <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      wsh         <= '0;
      ack_sh      <= '0;
      rsh         <= '0;
      rpar        <= 1'b0;
      retries     <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_ack     <= '0;
      rsp_rdata   <= '0;
      rsp_perr    <= 1'b0;
      rsp_retries <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      icnt        <= icnt_n;
      swdio_o     <= o_n;
      swdio_oe    <= oe_n;
      ap_q        <= ap_n;
      rnw_q       <= rnw_n;
      addr_q      <= addr_n;
      wd_q        <= wd_n;
      wsh         <= wsh_n;
      ack_sh      <= ack_n;
      rsh         <= rsh_n;
      rpar        <= rpar_n;
      retries     <= retries_n;
      req_ready   <= ready_n;
      rsp_valid   <= rv_n;
      rsp_ack     <= rack_n;
      rsp_rdata   <= rdata_n;
      rsp_perr    <= perr_n;
      rsp_retries <= rret_n;
    end
  end

endmodule

// File: tb/tb_swd_frame_engine.sv
// Scoreboard bench for swd_frame_engine with a scripted SWD target.
// Build with SWD_WAIT_RETRY_EN to exercise WAIT reissue.
module tb_swd_frame_engine;

  localparam int CD   = 2;
  localparam int TRN  = 1;
  localparam int DW   = 32;
  localparam int IDL  = 8;
  localparam int WR   = 8;
  localparam int LNOK = 8 + TRN + 3 + TRN + IDL;

  logic          sck = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_apndp = 1'b0;
  logic          req_rnw = 1'b0;
  logic [1:0]    req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [2:0]    rsp_ack;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_perr;
  logic [3:0]    rsp_retries;
  logic          busy;
  logic          swclk;
  logic          swdio_o;
  logic          swdio_oe;
  logic          swdio_i = 1'b1;

  always #5 sck = ~sck;

  swd_frame_engine #(
    .CLK_DIV     (CD),
    .TRN_CYCLES  (TRN),
    .DATA_W      (DW),
    .IDLE_CYCLES (IDL),
    .WAIT_RETRIES(WR)
  ) dut (
    .sck        (sck),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_apndp  (req_apndp),
    .req_rnw    (req_rnw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ack    (rsp_ack),
    .rsp_rdata  (rsp_rdata),
    .rsp_perr   (rsp_perr),
    .rsp_retries(rsp_retries),
    .busy       (busy),
    .swclk      (swclk),
    .swdio_o    (swdio_o),
    .swdio_oe   (swdio_oe),
    .swdio_i    (swdio_i)
  );

  typedef struct {
    string         name;
    logic [2:0]    ack;
    logic [DW-1:0] rdata;
    logic          chk_rd;
    logic          perr;
    logic [3:0]    retries;
    int            lat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;

  always @(posedge sck) cyc = cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // monitor: pops one expectation per response pulse
  always @(negedge sck) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_ack"}, 64'(rsp_ack), 64'(e.ack));
        if (e.chk_rd)
          chk({e.name, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
        chk({e.name, "_perr"}, 64'(rsp_perr), 64'(e.perr));
        chk({e.name, "_retries"}, 64'(rsp_retries),
            64'(e.retries));
        chk({e.name, "_lat"}, 64'(cyc - acc_cyc), 64'(e.lat));
        done_cnt++;
      end
    end
  end

  // scripted target, one SWCLK cycle per rising swclk
  int            txn_id = 0;
  int            seen_id = 0;
  int            tg = -1;
  logic [2:0]    t_ack = 3'b001;
  int            t_nwait = 0;
  logic [DW-1:0] t_rdata = '0;
  logic          t_flip = 1'b0;
  logic          t_rnw = 1'b0;
  logic          rec_o  [256];
  logic          rec_oe [256];

  function automatic logic tgt_bit(input int g);
    int a;
    int o;
    logic [2:0] ak;
    a = g / LNOK;
    if (a > t_nwait) a = t_nwait;
    o = g - a * LNOK;
    ak = (a < t_nwait) ? 3'b010 : t_ack;
    if (o >= 8 + TRN && o < 11 + TRN) return ak[o - 8 - TRN];
    if (ak == 3'b001 && t_rnw) begin
      if (o >= 11 + TRN && o < 11 + TRN + DW)
        return t_rdata[o - 11 - TRN];
      if (o == 11 + TRN + DW) return (^t_rdata) ^ t_flip;
    end
    return 1'b1;
  endfunction

  always @(posedge swclk) begin
    if (seen_id != txn_id) begin
      seen_id = txn_id;
      tg = -1;
    end
    tg = tg + 1;
    if (tg >= 0 && tg < 256) begin
      rec_o[tg]  = swdio_o;
      rec_oe[tg] = swdio_oe;
    end
    swdio_i = tgt_bit(tg + 1);
  end

  function automatic logic [7:0] hdr_at(input int base);
    logic [7:0] h;
    for (int i = 0; i < 8; i++) h[i] = rec_o[base + i];
    return h;
  endfunction

  task automatic chk_oe(input string nm, input int len,
                        input int lo, input int hi);
    int errs = 0;
    for (int i = 0; i < len; i++) begin
      if (rec_oe[i] !== ((i >= lo && i <= hi) ? 1'b0 : 1'b1))
        errs++;
    end
    chk(nm, 64'(errs), 64'd0);
  endtask

  task automatic chk_post_low(input string nm, input int len);
    int ones = 0;
    for (int i = len - IDL; i < len; i++)
      if (rec_o[i] !== 1'b0) ones++;
    chk(nm, 64'(ones), 64'd0);
  endtask

  task automatic issue(input logic ap, input logic rnw,
                       input logic [1:0] addr,
                       input logic [DW-1:0] wd);
    int n = 0;
    @(negedge sck);
    while (!req_ready && n < 1000) begin
      @(negedge sck);
      n++;
    end
    req_apndp = ap;
    req_rnw   = rnw;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    txn_id++;
    @(posedge sck);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int tgt);
    int n = 0;
    while (done_cnt < tgt && n < 2000) begin
      @(negedge sck);
      n++;
    end
    chk({nm, "_done"}, 64'(done_cnt >= tgt), 64'd1);
    repeat (4) @(negedge sck);
  endtask

  task automatic push(input string nm, input logic [2:0] ack,
                      input logic [DW-1:0] rd, input logic crd,
                      input logic perr, input logic [3:0] rt,
                      input int lat);
    exp_t e;
    e.name = nm;
    e.ack = ack;
    e.rdata = rd;
    e.chk_rd = crd;
    e.perr = perr;
    e.retries = rt;
    e.lat = lat;
    q.push_back(e);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge sck);
    chk("reset_pins",
        64'({swclk, swdio_o, swdio_oe, req_ready, busy}),
        64'(5'b00010));
    chk("reset_rsp",
        64'({rsp_valid, rsp_ack, rsp_perr, rsp_retries}),
        64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge sck);

    // DP read IDCODE: 54 SWCLK cycles
    t_ack = 3'b001; t_nwait = 0; t_rnw = 1'b1;
    t_rdata = 32'h2BA01477; t_flip = 1'b0;
    push("rd_idcode", 3'b001, 32'h2BA01477, 1'b1, 1'b0,
         4'd0, 54 * 4 + 1);
    issue(1'b0, 1'b1, 2'd0, '0);
    wait_done("rd_idcode", 1);
    chk("rd_hdr", 64'(hdr_at(0)), 64'h A5);
    chk_oe("rd_oe_map", 54, 8, 45);
    chk_post_low("rd_post", 54);

    // AP write addr 1
    t_ack = 3'b001; t_rnw = 1'b0;
    push("wr_ap", 3'b001, '0, 1'b0, 1'b0, 4'd0, 54 * 4 + 1);
    issue(1'b1, 1'b0, 2'd1, 32'hA5A5A5A5);
    wait_done("wr_ap", 2);
    chk("wr_hdr", 64'(hdr_at(0)), 64'h8B);
    chk_oe("wr_oe_map", 54, 8, 12);
    begin
      logic [32:0] cap;
      for (int i = 0; i < 33; i++) cap[i] = rec_o[13 + i];
      chk("wr_data", 64'(cap), 64'h0_A5A5A5A5);
    end
    chk_post_low("wr_post", 54);

    // AP read addr 3, target corrupts parity
    t_ack = 3'b001; t_rnw = 1'b1;
    t_rdata = 32'h12345678; t_flip = 1'b1;
    push("rd_perr", 3'b001, 32'h12345678, 1'b1, 1'b1,
         4'd0, 54 * 4 + 1);
    issue(1'b1, 1'b1, 2'd3, '0);
    wait_done("rd_perr", 3);
    t_flip = 1'b0;

    // FAULT on a write: 21 SWCLK cycles, no data phase
    t_ack = 3'b100; t_rnw = 1'b0;
    push("fault", 3'b100, '0, 1'b0, 1'b0, 4'd0, 21 * 4 + 1);
    issue(1'b1, 1'b0, 2'd2, 32'hFFFF0000);
    wait_done("fault", 4);
    chk_oe("fault_oe_map", 21, 8, 12);
    chk_post_low("fault_post", 21);

`ifdef SWD_WAIT_RETRY_EN
    // WAIT twice then OK: three headers, one response
    t_ack = 3'b001; t_nwait = 2; t_rnw = 1'b1;
    t_rdata = 32'hCAFEF00D;
    push("wait_retry", 3'b001, 32'hCAFEF00D, 1'b1, 1'b0,
         4'd2, (2 * LNOK + 54) * 4 + 1);
    issue(1'b0, 1'b1, 2'd1, '0);
    wait_done("wait_retry", 5);
    chk("retry_hdr0", 64'(hdr_at(0)), 64'h8D);
    chk("retry_hdr1", 64'(hdr_at(LNOK)), 64'h8D);
    chk("retry_hdr2", 64'(hdr_at(2 * LNOK)), 64'h8D);
    t_nwait = 0;
`else
    // WAIT ends the transaction like FAULT
    t_ack = 3'b010; t_nwait = 0; t_rnw = 1'b1;
    push("wait_plain", 3'b010, '0, 1'b0, 1'b0, 4'd0,
         21 * 4 + 1);
    issue(1'b0, 1'b1, 2'd1, '0);
    wait_done("wait_plain", 5);
    chk("wait_hdr", 64'(hdr_at(0)), 64'h8D);
`endif

    // reset in the middle of RDATA
    t_ack = 3'b001; t_nwait = 0; t_rnw = 1'b1;
    t_rdata = 32'h2BA01477;
    issue(1'b0, 1'b1, 2'd0, '0);
    n = 0;
    while (tg < 20 && n < 500) begin
      @(negedge sck);
      n++;
    end
    chk("rst_reach_rdata", 64'(tg >= 20), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pins",
        64'({swclk, swdio_oe, req_ready, busy, rsp_valid}),
        64'(5'b00100));
    repeat (2) @(negedge sck);
    rst_n = 1'b1;
    repeat (2) @(negedge sck);

    push("after_rst", 3'b001, 32'h2BA01477, 1'b1, 1'b0,
         4'd0, 54 * 4 + 1);
    issue(1'b0, 1'b1, 2'd0, '0);
    wait_done("after_rst", 6);
    chk("after_rst_hdr", 64'(hdr_at(0)), 64'hA5);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
